// File: rtl/pixel_top.sv
`default_nettype none
// ============================================================================
// pixel_top : 2x2 image-sensor pixel array with global frame controller
// Rev 1.0
// ============================================================================
module pixel_top #(
   parameter int unsigned C_ERASE   = 5,
   parameter int unsigned C_EXPOSE  = 255,
   parameter int unsigned C_CONVERT = 256,
   parameter int unsigned C_READ    = 5,
   parameter logic [15:0] DV1       = 16'd128,
   parameter logic [15:0] DV2       = 16'd192,
   parameter logic [15:0] DV3       = 16'd256,
   parameter logic [15:0] DV4       = 16'd64
) (
   input  logic       clk,
   input  logic       reset,
   inout  tri   [7:0] pixData1,
   inout  tri   [7:0] pixData2,
   inout  tri   [7:0] pixData3,
   inout  tri   [7:0] pixData4
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ERASE   = 3'd1,
      S_EXPOSE  = 3'd2,
      S_CONVERT = 3'd3,
      S_READ    = 3'd4
   } state_t;

   localparam logic [8:0]  LAST_ERASE   = 9'(C_ERASE - 1);
   localparam logic [8:0]  LAST_EXPOSE  = 9'(C_EXPOSE - 1);
   localparam logic [8:0]  LAST_CONVERT = 9'(C_CONVERT - 1);
   localparam logic [8:0]  LAST_READ    = 9'(C_READ - 1);
   localparam logic [15:0] DV [4]       = '{DV1, DV2, DV3, DV4};

   state_t          state_q;
   logic [8:0]      cnt_q;
   logic            last_w;
   logic [7:0]      ramp_w;
   logic            read_w;
   logic [3:0][7:0] data_w;

   always_comb begin
      last_w = 1'b1;
      case (state_q)
         S_ERASE:   last_w = (cnt_q == LAST_ERASE);
         S_EXPOSE:  last_w = (cnt_q == LAST_EXPOSE);
         S_CONVERT: last_w = (cnt_q == LAST_CONVERT);
         S_READ:    last_w = (cnt_q == LAST_READ);
         default:   last_w = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else if (last_w) begin
         cnt_q <= '0;
         case (state_q)
            S_IDLE:    state_q <= S_ERASE;
            S_ERASE:   state_q <= S_EXPOSE;
            S_EXPOSE:  state_q <= S_CONVERT;
            S_CONVERT: state_q <= S_READ;
            default:   state_q <= S_IDLE;
         endcase
      end else begin
         cnt_q <= cnt_q + 9'd1;
      end
   end

   assign ramp_w = cnt_q[7:0];
   assign read_w = (state_q == S_READ);

   for (genvar i = 0; i < 4; i++) begin : g_pix
      logic [15:0] acc_q;
      logic [7:0]  data_q;
      logic        latched_q;
      logic [16:0] sum_d;

      // Carry out of the 17-bit sum means the accumulator must clamp.
      assign sum_d     = {1'b0, acc_q} + {1'b0, DV[i]};
      assign data_w[i] = data_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            acc_q     <= '0;
            data_q    <= '0;
            latched_q <= 1'b0;
         end else begin
            case (state_q)
               S_ERASE:  acc_q <= '0;
               S_EXPOSE: acc_q <= sum_d[16] ? 16'hFFFF : sum_d[15:0];
               default:  acc_q <= acc_q;
            endcase
            if (state_q == S_EXPOSE && last_w) begin
               latched_q <= 1'b0;
            end else if (state_q == S_CONVERT && !latched_q && ramp_w >= acc_q[15:8]) begin
               data_q    <= ramp_w;
               latched_q <= 1'b1;
            end
         end
      end
   end

   assign pixData1 = read_w ? data_w[0] : 8'hzz;
   assign pixData2 = read_w ? data_w[1] : 8'hzz;
   assign pixData3 = read_w ? data_w[2] : 8'hzz;
   assign pixData4 = read_w ? data_w[3] : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_pixel_top.sv
`default_nettype none
// ============================================================================
// tb_pixel_top : checks two pixel_top instances (default and saturating/zero DVs)
// Rev 1.0
// ============================================================================
module tb_pixel_top;

   localparam int unsigned FRAME = 522;
   localparam int unsigned RD_LO = 517;
   localparam int unsigned RD_HI = 521;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ext_en = 1'b0;
   logic [7:0] ext_val = 8'h00;

   tri [7:0] pa1, pa2, pa3, pa4, pb1, pb2, pb3, pb4;

   int unsigned pos = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // External driver that must never fight the DUT outside READ
   assign pa1 = ext_en ? ext_val : 8'hzz;
   assign pa2 = ext_en ? ext_val : 8'hzz;
   assign pa3 = ext_en ? ext_val : 8'hzz;
   assign pa4 = ext_en ? ext_val : 8'hzz;
   assign pb1 = ext_en ? ext_val : 8'hzz;
   assign pb2 = ext_en ? ext_val : 8'hzz;
   assign pb3 = ext_en ? ext_val : 8'hzz;
   assign pb4 = ext_en ? ext_val : 8'hzz;

   pixel_top dut_a (
      .clk(clk), .reset(reset),
      .pixData1(pa1), .pixData2(pa2), .pixData3(pa3), .pixData4(pa4)
   );

   pixel_top #(.DV3(16'd1024), .DV4(16'd0)) dut_b (
      .clk(clk), .reset(reset),
      .pixData1(pb1), .pixData2(pb2), .pixData3(pb3), .pixData4(pb4)
   );

   typedef struct packed {
      int unsigned     cyc;
      logic            rd;
      logic [3:0][7:0] ea;
      logic [3:0][7:0] eb;
   } vec_t;

   vec_t tbl[$];

   // Reference: final code is the high byte of min(DV*255, 65535)
   function automatic logic [7:0] ref_code(input int unsigned dv);
      longint unsigned e;
      e = longint'(dv) * 255;
      if (e > 65535) e = 65535;
      return 8'(e / 256);
   endfunction

   task automatic tick(input logic rst);
      ext_en = 1'b0;
      reset  = rst;
      @(posedge clk);
      pos = rst ? 0 : pos + 1;
      #1;
   endtask

   task automatic check_all(input string nm, input logic rd,
                            input logic [3:0][7:0] ea, input logic [3:0][7:0] eb);
      logic [7:0] act [8];
      logic [7:0] exp [8];
      logic [7:0] pat;
      pat = 8'($urandom);
      if (!rd) begin
         ext_val = pat;
         ext_en  = 1'b1;
      end
      #1;
      act = '{pa1, pa2, pa3, pa4, pb1, pb2, pb3, pb4};
      for (int i = 0; i < 8; i++) begin
         exp[i] = rd ? ((i < 4) ? ea[i] : eb[i-4]) : pat;
         checks++;
         if (act[i] !== exp[i]) begin
            errors++;
            $display("FAIL %s bus%0d pos=%0d: got %h expected %h (read=%0b)",
                     nm, i, pos, act[i], exp[i], rd);
         end
      end
      ext_en = 1'b0;
   endtask

   task automatic model_check(input string nm);
      int unsigned f;
      logic [3:0][7:0] ea, eb;
      f = pos % FRAME;
      ea = {ref_code(64), ref_code(256), ref_code(192), ref_code(128)};
      eb = {ref_code(0), ref_code(1024), ref_code(192), ref_code(128)};
      check_all(nm, (f >= RD_LO && f <= RD_HI), ea, eb);
   endtask

   task automatic run_checked(input int n, input string nm);
      for (int k = 0; k < n; k++) begin
         tick(1'b0);
         model_check(nm);
      end
   endtask

   task automatic add(input int unsigned cyc, input logic rd);
      vec_t v;
      v.cyc = cyc;
      v.rd  = rd;
      v.ea  = rd ? {8'd63, 8'd255, 8'd191, 8'd127} : '0;
      v.eb  = rd ? {8'd0,  8'd255, 8'd191, 8'd127} : '0;
      tbl.push_back(v);
   endtask

   initial begin
      add(0, 0);    add(1, 0);    add(5, 0);    add(6, 0);
      add(260, 0);  add(261, 0);  add(516, 0);  add(517, 1);
      add(519, 1);  add(521, 1);  add(522, 0);  add(523, 0);
      add(1038, 0); add(1039, 1); add(1043, 1); add(1044, 0);

      // Vector table: first two frames after a single-cycle reset
      tick(1'b1);
      foreach (tbl[j]) begin
         while (pos < tbl[j].cyc) tick(1'b0);
         check_all($sformatf("vec%0d", j), tbl[j].rd, tbl[j].ea, tbl[j].eb);
      end

      // Reset in the middle of CONVERT of frame 2, then a full fresh frame
      tick(1'b1);
      model_check("rst_a");
      run_checked(FRAME + 300, "pre_abort");
      tick(1'b1);
      model_check("abort");
      run_checked(FRAME + 10, "post_abort");

      // Reset held several cycles, then released
      for (int k = 0; k < 4; k++) begin
         tick(1'b1);
         model_check("rst_hold");
      end
      run_checked(FRAME + 5, "after_hold");

      // Randomized resets against the frame-position model
      for (int k = 0; k < 3000; k++) begin
         tick($urandom_range(0, 599) == 0);
         model_check("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
